sign_packer: RTL and testbench

Downstream stage of the per-dimension bundling counters. Each accepted strobe carries one sign bit from each of `LANES` counters, one bit per dimension. The block packs consecutive strobes into `DW`-bit binary hypervector words and emits them on a valid/ready output stream toward the result DMA. It frames the hypervector with `out_last` and pulses `done` when the final word has left the block.

---
 rtl/hpu_pkg.sv | 14 +
 rtl/sign_out_fifo.sv | 71 +++++++
 rtl/sign_packer.sv | 140 ++++++++++++++
 tb/tb_sign_packer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/hpu_pkg.sv
// Shared types and default geometry for the HPU result path.
package hpu_pkg;

    localparam int unsigned LANES_DEF        = 4;
    localparam int unsigned DW_DEF           = 32;
    localparam int unsigned STROBES_PER_WORD = DW_DEF / LANES_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        DRAIN = 2'd2
    } sp_state_t;

endpackage : hpu_pkg

// File: rtl/sign_out_fifo.sv
// Two-entry output FIFO; the head entry is a flop so the stream outputs are registered.
module sign_out_fifo #(
    parameter int unsigned W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         full_q, full_d;
    logic         empty_q, empty_d;
    logic         pop_ok, push_ok;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        pop_ok  = pop && (count_q != 2'd0);
        push_ok = push && ((count_q != 2'd2) || pop_ok);
        case (count_q)
            2'd0: begin
                if (push_ok) head_d = push_data;
            end
            2'd1: begin
                if (push_ok && pop_ok) head_d = push_data;
                else if (push_ok)      tail_d = push_data;
            end
            2'd2: begin
                // Head retires: tail slides forward, any new word refills the tail.
                if (pop_ok) begin
                    head_d = tail_q;
                    if (push_ok) tail_d = push_data;
                end
            end
            default: ;
        endcase
        count_d = count_q + 2'(push_ok) - 2'(pop_ok);
        full_d  = (count_d == 2'd2);
        empty_d = (count_d == 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign head  = head_q;
    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule : sign_out_fifo

// File: rtl/sign_packer.sv
// Packs per-lane sign strobes into DW-bit hypervector words on a valid/ready stream.
module sign_packer
    import hpu_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned CW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CW-1:0]    cfg_words,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LANES-1:0] in_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int unsigned SPW  = DW / LANES;
    localparam int unsigned IDXW = (SPW > 1) ? $clog2(SPW) : 1;

    sp_state_t       state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [CW-1:0]   words_q, words_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic [DW-1:0]   shreg_q, shreg_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            accept, completing, last_word;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [1:0]      fifo_count, count_nxt;
    logic [DW:0]     fifo_head;

    assign fifo_pop = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        words_d    = words_q;
        wcnt_d     = wcnt_q;
        shreg_d    = shreg_q;
        done_d     = 1'b0;
        completing = 1'b0;
        last_word  = 1'b0;
        accept     = in_valid && in_ready_q && (state_q == PACK);

        case (state_q)
            IDLE: begin
                if (start && (cfg_words != '0)) begin
                    words_d = cfg_words;
                    idx_d   = '0;
                    wcnt_d  = '0;
                    shreg_d = '0;
                    state_d = PACK;
                end
            end
            PACK: begin
                if (accept) begin
                    shreg_d[int'(idx_q) * LANES +: LANES] = in_sign;
                    if (idx_q == IDXW'(SPW - 1)) begin
                        completing = 1'b1;
                        idx_d      = '0;
                        wcnt_d     = wcnt_q + CW'(1);
                        if (wcnt_q == words_q - CW'(1)) begin
                            last_word = 1'b1;
                            state_d   = DRAIN;
                        end
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
            end
            DRAIN: begin
                if (fifo_pop && out_last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        fifo_push = completing && (!fifo_full || fifo_pop);
        count_nxt = fifo_count + 2'(fifo_push) - 2'(fifo_pop);
        // Ready is precomputed from next-cycle state so it never depends on out_ready combinationally.
        in_ready_d = (state_d == PACK) &&
                     !((idx_d == IDXW'(SPW - 1)) && (count_nxt == 2'd2));
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            words_q    <= '0;
            wcnt_q     <= '0;
            shreg_q    <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            words_q    <= words_d;
            wcnt_q     <= wcnt_d;
            shreg_q    <= shreg_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    sign_out_fifo #(
        .W (DW + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({last_word, shreg_d}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head[DW-1:0];
    assign out_last  = fifo_head[DW];
    assign busy      = busy_q;
    assign done      = done_q;

endmodule : sign_packer

// File: tb/tb_sign_packer.sv
// Directed bench for sign_packer with LANES=4, DW=32 (8 strobes per word).
module tb_sign_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cfg_words;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_sign;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    sign_packer #(.LANES(4), .DW(32), .CW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_words (cfg_words),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] cfg);
        start = 1'b1; cfg_words = cfg;
        tick();
        start = 1'b0;
    endtask

    task automatic strobe(input logic [3:0] s);
        int waits = 0;
        in_valid = 1'b1; in_sign = s;
        while (in_ready !== 1'b1 && waits < 64) begin
            tick();
            waits++;
        end
        if (in_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL strobe_timeout in_ready=%b expected 1", in_ready);
        end else begin
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cfg_words = '0; in_valid = 1'b0; in_sign = '0; out_ready = 1'b0;
        tick(); tick();
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 32'h0) $display("FAIL rst_out_data got %h exp 0", out_data); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL rst_out_last got %b exp 0", out_last); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done got %b exp 0", done); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_word();
        out_ready = 1'b1;
        do_start(16'd1);
        n_checks++; if (busy !== 1'b1) $display("FAIL single_busy_rise got %b exp 1", busy); else n_pass++;
        for (int k = 0; k < 8; k++) strobe(4'hA);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", out_valid); else n_pass++;
        n_checks++; if (out_data !== 32'hAAAAAAAA) $display("FAIL single_data got %h exp aaaaaaaa", out_data); else n_pass++;
        n_checks++; if (out_last !== 1'b1) $display("FAIL single_last got %b exp 1", out_last); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL single_drain_ready got %b exp 0", in_ready); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b1) $display("FAIL single_done got %b exp 1", done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_fall got %b exp 0", busy); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL single_valid_fall got %b exp 0", out_valid); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b0) $display("FAIL single_done_pulse got %b exp 0", done); else n_pass++;
    endtask

    task automatic test_bit_order();
        logic [3:0] s;
        out_ready = 1'b0;
        do_start(16'd1);
        for (int k = 0; k < 8; k++) begin
            s = 4'(k);
            strobe(s);
        end
        n_checks++; if (out_data !== 32'h76543210) $display("FAIL order_data got %h exp 76543210", out_data); else n_pass++;
        out_ready = 1'b1;
        tick();
        n_checks++; if (done !== 1'b1) $display("FAIL order_done got %b exp 1", done); else n_pass++;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        do_start(16'd3);
        for (int k = 0; k < 8; k++) strobe(4'h1);
        for (int k = 0; k < 8; k++) strobe(4'h2);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_partial_ready got %b exp 1", in_ready); else n_pass++;
        for (int k = 0; k < 7; k++) strobe(4'h3);
        in_valid = 1'b1; in_sign = 4'h3;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready_drop got %b exp 0", in_ready); else n_pass++;
        tick(); tick(); tick();
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready_held got %b exp 0", in_ready); else n_pass++;
        n_checks++; if (out_data !== 32'h11111111) $display("FAIL bp_word0 got %h exp 11111111", out_data); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL bp_word0_last got %b exp 0", out_last); else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back got %b exp 1", in_ready); else n_pass++;
        n_checks++; if (out_data !== 32'h22222222) $display("FAIL bp_word1 got %h exp 22222222", out_data); else n_pass++;
        tick();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready_after_last got %b exp 0", in_ready); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL bp_word1_last got %b exp 0", out_last); else n_pass++;
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_data !== 32'h33333333) $display("FAIL bp_word2 got %h exp 33333333", out_data); else n_pass++;
        n_checks++; if (out_last !== 1'b1) $display("FAIL bp_word2_last got %b exp 1", out_last); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b1) $display("FAIL bp_done got %b exp 1", done); else n_pass++;
        tick();
    endtask

    task automatic test_stall_stability();
        logic r;
        logic handshaken = 1'b0;
        out_ready = 1'b0;
        do_start(16'd1);
        for (int k = 0; k < 8; k++) strobe((k % 2 == 0) ? 4'h5 : 4'hC);
        for (int c = 0; c < 24 && !handshaken; c++) begin
            r = (c == 0) ? 1'b0 : ((c == 23) ? 1'b1 : 1'($urandom_range(0, 3) == 0));
            out_ready = r;
            n_checks++; if (out_data !== 32'hC5C5C5C5) $display("FAIL stall_data cyc %0d got %h exp c5c5c5c5", c, out_data); else n_pass++;
            n_checks++; if (out_last !== 1'b1 || out_valid !== 1'b1) $display("FAIL stall_last_valid cyc %0d got %b%b exp 11", c, out_last, out_valid); else n_pass++;
            tick();
            handshaken = r;
        end
        out_ready = 1'b1;
        n_checks++; if (done !== 1'b1) $display("FAIL stall_done got %b exp 1", done); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        do_start(16'd2);
        for (int k = 0; k < 3; k++) strobe(4'h9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rmid_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rmid_ready got %b exp 0", in_ready); else n_pass++;
        do_start(16'd1);
        for (int k = 0; k < 8; k++) strobe(4'hF);
        n_checks++; if (out_data !== 32'hFFFFFFFF) $display("FAIL rmid_data got %h exp ffffffff", out_data); else n_pass++;
        n_checks++; if (out_last !== 1'b1) $display("FAIL rmid_last got %b exp 1", out_last); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b1) $display("FAIL rmid_done got %b exp 1", done); else n_pass++;
        tick();
    endtask

    task automatic test_ignored_start();
        out_ready = 1'b1;
        do_start(16'd0);
        n_checks++; if (busy !== 1'b0) $display("FAIL ign_zero_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL ign_zero_ready got %b exp 0", in_ready); else n_pass++;
        do_start(16'd2);
        for (int k = 0; k < 4; k++) strobe(4'h7);
        do_start(16'd5);
        n_checks++; if (busy !== 1'b1) $display("FAIL ign_busy_start got %b exp 1", busy); else n_pass++;
        for (int k = 0; k < 4; k++) strobe(4'h7);
        n_checks++; if (out_data !== 32'h77777777) $display("FAIL ign_word0 got %h exp 77777777", out_data); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL ign_word0_last got %b exp 0", out_last); else n_pass++;
        for (int k = 0; k < 8; k++) strobe(4'h8);
        n_checks++; if (out_data !== 32'h88888888) $display("FAIL ign_word1 got %h exp 88888888", out_data); else n_pass++;
        n_checks++; if (out_last !== 1'b1) $display("FAIL ign_word1_last got %b exp 1", out_last); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b1) $display("FAIL ign_done got %b exp 1", done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL ign_busy_end got %b exp 0", busy); else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_bit_order();
        test_backpressure();
        test_stall_stability();
        test_reset_mid();
        test_ignored_start();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_sign_packer
